ar_tag_arbiter: RTL and testbench
=================================

Name: ar_tag_arbiter

Overview:
- Shares one AXI read-address (AR) channel among NUM_PORTS requesters.
- Arbitration is strict QoS priority, with round-robin among requesters of equal QoS.
- Each granted request is assigned a free reorder tag from a pool of 2^TAG_WIDTH entries. The tag is carried on out_tagid; the reorder logic returns it through the release port.
- Sits between the requester AR ports and the downstream AR master port feeding the reorder buffer.

Parameters:
NUM_PORTS, 4, number of requesters (>=2)
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, address width
LEN_WIDTH, 8, burst length width
TAG_WIDTH, 4, tag index width; pool depth 2^TAG_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_PORTS  per-requester AR valid
in_ready  out  NUM_PORTS  per-requester AR ready
in_id  in  NUM_PORTS*ID_WIDTH  packed IDs, port p at [p*ID_WIDTH +: ID_WIDTH]
in_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses
in_len  in  NUM_PORTS*LEN_WIDTH  packed lengths
in_size  in  NUM_PORTS*3  packed sizes
in_burst  in  NUM_PORTS*2  packed burst types
in_qos  in  NUM_PORTS*4  packed QoS values
out_valid  out  1  AR valid to downstream
out_ready  in  1  AR ready from downstream
out_id, out_addr, out_len, out_size, out_burst, out_qos  out  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2/4  granted request fields
out_tagid  out  TAG_WIDTH  allocated tag
out_src  out  $clog2(NUM_PORTS)  index of granted requester
rel_valid  in  1  tag release strobe
rel_tag  in  TAG_WIDTH  tag being released
tags_used  out  TAG_WIDTH+1  count of allocated tags
rel_err  out  1  one-cycle pulse on release of an already-free tag

Behaviour:
- Single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0; all out_* fields, out_tagid, out_src = 0.
  - in_ready=0, rel_err=0, tags_used=0.
  - All tags free; round-robin pointer = 0.
- Output stage is one register slot.
  - can_load = (!out_valid || out_ready) && (tags_used < 2^TAG_WIDTH) && any in_valid.
- Arbitration (combinational, every cycle):
  - Find the max in_qos among valid ports.
  - Among valid ports with that QoS, the winner g is the first index at or after rr_ptr, wrapping modulo NUM_PORTS.
- Grant:
  - in_ready[g]=1 only when can_load; all other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid, out_ready and the tag state.
- On grant, at the clock edge:
  - Capture port g's fields into the out_* registers; out_src=g.
  - out_tagid = lowest-index free tag; mark it busy.
  - out_valid=1; rr_ptr = (g+1) mod NUM_PORTS.
- Latency: request accepted in cycle N appears on out_valid in cycle N+1.
- Full throughput: one grant per cycle when out_ready=1 and tags are available.
- Stability: while out_valid && !out_ready, all out_* fields and out_tagid hold, and in_ready stays 0.
- out_valid falls after a handshake only if no new grant occurs in that same cycle.
- Tag release:
  - rel_valid with a busy rel_tag clears the busy bit at the edge.
  - The released tag is allocatable from the next cycle; same-cycle allocation uses the pre-edge state.
  - Release of a free tag: state unchanged, rel_err=1 for one cycle.
- tags_used:
  - Increments on grant, decrements on a valid release.
  - Grant and valid release in the same cycle leave it unchanged.
  - Never exceeds 2^TAG_WIDTH.
- Pool exhausted: no grants (in_ready all 0) until a release. A request already in the output slot still completes.
- Strict QoS may starve lower-QoS ports by design. Round-robin fairness applies only within the same QoS level.
- Reset asserted mid-operation: the output slot is dropped immediately; the pool and pointer return to reset values.
- Requesters must hold in_valid and their fields stable until in_ready (AXI rule). This block does not check it.

Test Plan:
- Ports 0–3 continuously valid, all qos=0, out_ready=1 -> grants cycle 0,1,2,3,0; out_tagid 0,1,2,3,4; out_valid high from the cycle after the first grant.
- Port 1 qos=2, port 3 qos=5, both valid -> port 3 granted first (out_src=3), port 1 on the next cycle.
- out_ready=0 for 3 cycles while out_valid=1 -> out_* and out_tagid unchanged, in_ready=0; on out_ready=1 the next grant loads in the same cycle.
- Allocate all 16 tags (TAG_WIDTH=4) -> tags_used=16, in_ready=0; release tag 7 -> next grant gets out_tagid=7, tags_used back to 16.
- Release an already-free tag 9 -> rel_err pulses 1 cycle, tags_used unchanged; grant plus valid release in the same cycle -> tags_used unchanged.
- Assert rst_n=0 while out_valid=1 with 5 tags in use -> out_valid=0 immediately, tags_used=0; after release the first grant gets out_tagid=0 from port 0.

Source files
------------

// File: rtl/ar_tag_arbiter_if.sv
// AR request/grant bundle between requesters, the tag arbiter and the downstream
// reorder-buffer master port, plus the tag release path.
interface ar_tag_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
);
  localparam int SRC_WIDTH = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS*ID_WIDTH-1:0]   in_id;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr;
  logic [NUM_PORTS*LEN_WIDTH-1:0]  in_len;
  logic [NUM_PORTS*3-1:0]          in_size;
  logic [NUM_PORTS*2-1:0]          in_burst;
  logic [NUM_PORTS*4-1:0]          in_qos;

  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [LEN_WIDTH-1:0]  out_len;
  logic [2:0]            out_size;
  logic [1:0]            out_burst;
  logic [3:0]            out_qos;
  logic [TAG_WIDTH-1:0]  out_tagid;
  logic [SRC_WIDTH-1:0]  out_src;

  logic                 rel_valid;
  logic [TAG_WIDTH-1:0] rel_tag;
  logic [TAG_WIDTH:0]   tags_used;
  logic                 rel_err;

  modport slave (
    input  in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos,
    output in_ready,
    output out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
    output out_tagid, out_src,
    input  out_ready,
    input  rel_valid, rel_tag,
    output tags_used, rel_err
  );

  modport master (
    output in_valid, in_id, in_addr, in_len, in_size, in_burst, in_qos,
    input  in_ready,
    input  out_valid, out_id, out_addr, out_len, out_size, out_burst, out_qos,
    input  out_tagid, out_src,
    output out_ready,
    output rel_valid, rel_tag,
    input  tags_used, rel_err
  );
endinterface

// File: rtl/ar_tag_arbiter.sv
// Strict-QoS / round-robin AR channel arbiter with a one-slot output register
// and a reorder tag pool (lowest free tag allocated on each grant).
module ar_tag_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ar_tag_arbiter_if.slave    bus
);
  localparam int SRC_WIDTH = $clog2(NUM_PORTS);
  localparam int DEPTH     = 1 << TAG_WIDTH;

  logic [ID_WIDTH-1:0]   id_arr    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [LEN_WIDTH-1:0]  len_arr   [NUM_PORTS];
  logic [2:0]            size_arr  [NUM_PORTS];
  logic [1:0]            burst_arr [NUM_PORTS];
  logic [3:0]            qos_arr   [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign id_arr[gi]    = bus.in_id[gi*ID_WIDTH +: ID_WIDTH];
      assign addr_arr[gi]  = bus.in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[gi]   = bus.in_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign size_arr[gi]  = bus.in_size[gi*3 +: 3];
      assign burst_arr[gi] = bus.in_burst[gi*2 +: 2];
      assign qos_arr[gi]   = bus.in_qos[gi*4 +: 4];
    end
  endgenerate

  logic                  out_valid_reg;
  logic [ID_WIDTH-1:0]   out_id_reg;
  logic [ADDR_WIDTH-1:0] out_addr_reg;
  logic [LEN_WIDTH-1:0]  out_len_reg;
  logic [2:0]            out_size_reg;
  logic [1:0]            out_burst_reg;
  logic [3:0]            out_qos_reg;
  logic [TAG_WIDTH-1:0]  out_tagid_reg;
  logic [SRC_WIDTH-1:0]  out_src_reg;
  logic [SRC_WIDTH-1:0]  rr_ptr_reg;
  logic [DEPTH-1:0]      busy_reg;
  logic [TAG_WIDTH:0]    tags_used_reg;
  logic                  rel_err_reg;

  logic                 any_valid;
  logic [3:0]           max_qos;
  logic                 found;
  logic [SRC_WIDTH-1:0] cand;
  logic [SRC_WIDTH-1:0] winner;
  logic [TAG_WIDTH-1:0] free_tag;
  logic                 pool_full;
  logic                 can_load;
  logic                 rel_hit;
  logic [NUM_PORTS-1:0] ready_vec;

  function automatic logic [SRC_WIDTH-1:0] port_at(input logic [SRC_WIDTH-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return SRC_WIDTH'(s);
  endfunction

  // Highest QoS wins; ties go to the first valid port at or after rr_ptr.
  always_comb begin
    any_valid = 1'b0;
    max_qos   = 4'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.in_valid[p]) begin
        any_valid = 1'b1;
        if (qos_arr[p] > max_qos) max_qos = qos_arr[p];
      end
    end
    found  = 1'b0;
    cand   = '0;
    winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = port_at(rr_ptr_reg, k);
      if (!found && bus.in_valid[cand] && qos_arr[cand] == max_qos) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    free_tag = '0;
    for (int t = DEPTH - 1; t >= 0; t--) begin
      if (!busy_reg[t]) free_tag = TAG_WIDTH'(t);
    end
  end

  assign pool_full = (tags_used_reg == (TAG_WIDTH+1)'(DEPTH));
  assign can_load  = rst_n && (!out_valid_reg || bus.out_ready) && !pool_full && any_valid;
  assign rel_hit   = bus.rel_valid && busy_reg[bus.rel_tag];

  always_comb begin
    ready_vec = '0;
    if (can_load) ready_vec[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
      out_addr_reg  <= '0;
      out_len_reg   <= '0;
      out_size_reg  <= '0;
      out_burst_reg <= '0;
      out_qos_reg   <= '0;
      out_tagid_reg <= '0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= '0;
      busy_reg      <= '0;
      tags_used_reg <= '0;
      rel_err_reg   <= 1'b0;
    end else begin
      rel_err_reg <= bus.rel_valid && !busy_reg[bus.rel_tag];
      // Allocated tag is free and released tag is busy, so the two never collide.
      if (rel_hit) busy_reg[bus.rel_tag] <= 1'b0;
      if (can_load) begin
        busy_reg[free_tag] <= 1'b1;
        out_valid_reg      <= 1'b1;
        out_id_reg         <= id_arr[winner];
        out_addr_reg       <= addr_arr[winner];
        out_len_reg        <= len_arr[winner];
        out_size_reg       <= size_arr[winner];
        out_burst_reg      <= burst_arr[winner];
        out_qos_reg        <= qos_arr[winner];
        out_tagid_reg      <= free_tag;
        out_src_reg        <= winner;
        rr_ptr_reg         <= port_at(winner, 1);
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      case ({can_load, rel_hit})
        2'b10:   tags_used_reg <= tags_used_reg + 1'b1;
        2'b01:   tags_used_reg <= tags_used_reg - 1'b1;
        default: tags_used_reg <= tags_used_reg;
      endcase
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_addr  = out_addr_reg;
  assign bus.out_len   = out_len_reg;
  assign bus.out_size  = out_size_reg;
  assign bus.out_burst = out_burst_reg;
  assign bus.out_qos   = out_qos_reg;
  assign bus.out_tagid = out_tagid_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.tags_used = tags_used_reg;
  assign bus.rel_err   = rel_err_reg;
endmodule

// File: tb/tb_ar_tag_arbiter.sv
// Randomized bench for ar_tag_arbiter against a behavioural model of the
// arbitration, output slot and tag pool.
module tb_ar_tag_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ar_tag_arbiter_if #(.NUM_PORTS(N), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .TAG_WIDTH(4)) bus_if ();

  ar_tag_arbiter #(.NUM_PORTS(N), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .TAG_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus knobs (percentages) and requester state.
  int vp, qmode, rp, lp;
  int force_rel = -1;
  bit          pend    [N];
  logic [3:0]  r_id    [N];
  logic [31:0] r_addr  [N];
  logic [7:0]  r_len   [N];
  logic [2:0]  r_size  [N];
  logic [1:0]  r_burst [N];
  logic [3:0]  r_qos   [N];
  bit          o_rdy;
  bit          rl_v;
  logic [3:0]  rl_tag;

  // Reference model.
  bit          m_busy [DEPTH];
  int          m_used, m_rr;
  bit          m_ov, m_relerr;
  logic [3:0]  m_id, m_qos, m_tag;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst, m_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int t = 0; t < DEPTH; t++) m_busy[t] = 1'b0;
    m_used = 0; m_rr = 0; m_ov = 1'b0; m_relerr = 1'b0;
    m_id = '0; m_qos = '0; m_tag = '0; m_addr = '0; m_len = '0;
    m_size = '0; m_burst = '0; m_src = '0;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      if (!pend[p] && $urandom_range(99) < vp) begin
        pend[p]    = 1'b1;
        r_id[p]    = 4'($urandom);
        r_addr[p]  = $urandom;
        r_len[p]   = 8'($urandom);
        r_size[p]  = 3'($urandom);
        r_burst[p] = 2'($urandom);
        r_qos[p]   = (qmode == 0) ? 4'd0 : 4'($urandom_range(3));
      end
      bus_if.in_valid[p]        = pend[p];
      bus_if.in_id[p*4 +: 4]    = r_id[p];
      bus_if.in_addr[p*32 +: 32] = r_addr[p];
      bus_if.in_len[p*8 +: 8]   = r_len[p];
      bus_if.in_size[p*3 +: 3]  = r_size[p];
      bus_if.in_burst[p*2 +: 2] = r_burst[p];
      bus_if.in_qos[p*4 +: 4]   = r_qos[p];
    end
    o_rdy = ($urandom_range(99) < rp);
    if (force_rel >= 0) begin
      rl_v = 1'b1; rl_tag = 4'(force_rel); force_rel = -1;
    end else begin
      rl_v = ($urandom_range(99) < lp); rl_tag = 4'($urandom);
    end
    bus_if.out_ready = o_rdy;
    bus_if.rel_valid = rl_v;
    bus_if.rel_tag   = rl_tag;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int maxq, g, best, d, ft;
    bit cl, hit;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    maxq = -1; g = -1; best = N;
    for (int p = 0; p < N; p++) if (pend[p] && int'(r_qos[p]) > maxq) maxq = int'(r_qos[p]);
    for (int p = 0; p < N; p++) begin
      if (pend[p] && int'(r_qos[p]) == maxq) begin
        d = (p - m_rr + N) % N;
        if (d < best) begin best = d; g = p; end
      end
    end
    cl = rst_n && (g >= 0) && (!m_ov || o_rdy) && (m_used < DEPTH);
    exp_rdy = '0;
    if (cl) exp_rdy[g] = 1'b1;
    chk("in_ready", bus_if.in_ready, exp_rdy);
    chk("out_valid", bus_if.out_valid, m_ov);
    chk("tags_used", bus_if.tags_used, m_used);
    chk("rel_err", bus_if.rel_err, m_relerr);
    if (m_ov) begin
      chk("out_id", bus_if.out_id, m_id);
      chk("out_addr", bus_if.out_addr, m_addr);
      chk("out_len", bus_if.out_len, m_len);
      chk("out_size", bus_if.out_size, m_size);
      chk("out_burst", bus_if.out_burst, m_burst);
      chk("out_qos", bus_if.out_qos, m_qos);
      chk("out_tagid", bus_if.out_tagid, m_tag);
      chk("out_src", bus_if.out_src, m_src);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      hit      = rl_v && m_busy[rl_tag];
      m_relerr = rl_v && !m_busy[rl_tag];
      ft = -1;
      for (int t = 0; t < DEPTH; t++) if (ft < 0 && !m_busy[t]) ft = t;
      if (hit) m_busy[rl_tag] = 1'b0;
      if (cl) begin
        m_busy[ft] = 1'b1;
        m_ov = 1'b1; m_tag = 4'(ft); m_src = 2'(g);
        m_id = r_id[g]; m_addr = r_addr[g]; m_len = r_len[g];
        m_size = r_size[g]; m_burst = r_burst[g]; m_qos = r_qos[g];
        m_rr = (g + 1) % N;
        pend[g] = 1'b0;
        $display("grant port=%0d qos=%0d tag=%0d addr=%08h used=%0d", g, m_qos, ft, m_addr, m_used + 1 - int'(hit));
      end else if (o_rdy) begin
        m_ov = 1'b0;
      end
      m_used = m_used + int'(cl) - int'(hit);
    end
    #1;
    drive_inputs();
  endtask

  task automatic mid_reset();
    int budget = 200;
    while (!(m_ov && m_used >= 2) && budget > 0) begin
      step();
      budget--;
    end
    chk("reset_wait", (budget > 0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus_if.out_valid, 1'b0);
    chk("rst_tags_used", bus_if.tags_used, 0);
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_out_tagid", bus_if.out_tagid, 0);
    $display("reset asserted mid-operation");
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    vp = 0; qmode = 0; rp = 100; lp = 0;
    model_reset();
    drive_inputs();
    #2 rst_n = 1'b0;
    vp = 100;
    drive_inputs();
    @(posedge clk);
    #1;
    chk("reset_out_valid", bus_if.out_valid, 1'b0);
    chk("reset_tags_used", bus_if.tags_used, 0);
    chk("reset_rel_err", bus_if.rel_err, 1'b0);
    chk("reset_in_ready", bus_if.in_ready, 0);
    chk("reset_out_tagid", bus_if.out_tagid, 0);
    chk("reset_out_src", bus_if.out_src, 0);
    chk("reset_out_addr", bus_if.out_addr, 0);
    rst_n = 1'b1;

    // Equal QoS, always ready: fills the pool in round-robin order, then stalls.
    repeat (24) step();
    force_rel = 7;
    drive_inputs();
    repeat (4) step();

    // Random traffic with QoS ties, backpressure and releases.
    vp = 50; qmode = 1; rp = 70; lp = 35;
    repeat (2500) step();

    mid_reset();
    // Release of a tag that is free after reset, then equal-QoS restart.
    vp = 100; qmode = 0; rp = 100; lp = 0;
    force_rel = 9;
    drive_inputs();
    repeat (10) step();

    vp = 60; qmode = 1; rp = 60; lp = 40;
    repeat (1500) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
